// File: rtl/division_4bits_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : division_4bits_ctrl
// Brief    : Signed 4-bit division sequencer. Resolves operand magnitudes
//            through the shared complement unit, runs a 3-step restoring
//            division on the magnitudes and applies the result signs.
// Revision : 1.0 - initial release
// ============================================================================
module division_4bits_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       comp_sel,
  output logic [3:0] comp_a,
  output logic [3:0] comp_b,
  output logic       comp_ci,
  input  logic [3:0] comp_sum,
  input  logic       comp_finish
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ_A = 3'd1;
  localparam logic [2:0] S_CAP_A = 3'd2;
  localparam logic [2:0] S_REQ_B = 3'd3;
  localparam logic [2:0] S_CAP_B = 3'd4;
  localparam logic [2:0] S_DIV   = 3'd5;
  localparam logic [2:0] S_SIGN  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [3:0] c_MOST_NEG = 4'b1000;

  logic [2:0] r_state;
  logic [2:0] w_next_state;

  logic [3:0] r_dvs;      // latched divisor, replayed to the unit in REQ_B
  logic       r_sa;
  logic       r_sb;
  logic [2:0] r_mag_a;
  logic [2:0] r_mag_b;
  logic [3:0] r_rem;
  logic [2:0] r_q;
  logic [1:0] r_cnt;

  logic       w_illegal;
  logic       w_bit;
  logic [3:0] w_r;
  logic       w_ge;
  logic [3:0] w_diff;
  logic [3:0] w_q_ext;
  logic [3:0] w_q_signed;
  logic [3:0] w_rem_signed;
  logic       w_unused_sum;

  // The unit only produces magnitudes 0..7 for legal operands, so bit 3 is
  // never meaningful here.
  assign w_unused_sum = comp_sum[3];

  // Fixed operand/carry for the complement unit: it computes 0 + ~a + 1.
  assign comp_b  = 4'b0000;
  assign comp_ci = 1'b1;

  // -8 has no 3-bit magnitude and a zero divisor is undefined.
  assign w_illegal = (dividend == c_MOST_NEG) || (divisor == c_MOST_NEG) ||
                     (divisor == 4'b0000);

  // Restoring-division step: bring down dividend bit i, subtract if it fits.
  always_comb begin
    w_bit = r_mag_a[0];
    if (r_cnt == 2'd2) begin
      w_bit = r_mag_a[2];
    end else if (r_cnt == 2'd1) begin
      w_bit = r_mag_a[1];
    end
    w_r    = {r_rem[2:0], w_bit};
    w_ge   = (w_r >= {1'b0, r_mag_b});
    w_diff = w_r - {1'b0, r_mag_b};
  end

  // Local two's-complement sign application for the results.
  always_comb begin
    w_q_ext      = {1'b0, r_q};
    w_q_signed   = (r_sa ^ r_sb) ? (~w_q_ext + 4'd1) : w_q_ext;
    w_rem_signed = r_sa ? (~r_rem + 4'd1) : r_rem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_illegal ? S_DONE : S_REQ_A;
        end
      end
      S_REQ_A: w_next_state = S_CAP_A;
      S_CAP_A: w_next_state = comp_finish ? S_REQ_B : S_DONE;
      S_REQ_B: w_next_state = S_CAP_B;
      S_CAP_B: w_next_state = comp_finish ? S_DIV : S_DONE;
      S_DIV:   w_next_state = (r_cnt == 2'd0) ? S_SIGN : S_DIV;
      S_SIGN:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    comp_sel = (r_state == S_REQ_A) || (r_state == S_REQ_B);
  end

  // Operand capture, magnitude capture, division iterations and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvs     <= 4'd0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_mag_a   <= 3'd0;
      r_mag_b   <= 3'd0;
      r_rem     <= 4'd0;
      r_q       <= 3'd0;
      r_cnt     <= 2'd0;
      err       <= 1'b0;
      quotient  <= 4'd0;
      remainder <= 4'd0;
      comp_a    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvs <= divisor;
            r_sa  <= dividend[3];
            r_sb  <= divisor[3];
            if (w_illegal) begin
              err       <= 1'b1;
              quotient  <= 4'd0;
              remainder <= 4'd0;
            end else begin
              comp_a <= dividend;
            end
          end
        end
        S_CAP_A: begin
          r_mag_a <= comp_sum[2:0];
          if (!comp_finish) begin
            err       <= 1'b1;
            quotient  <= 4'd0;
            remainder <= 4'd0;
          end else begin
            comp_a <= r_dvs;
          end
        end
        S_CAP_B: begin
          r_mag_b <= comp_sum[2:0];
          if (!comp_finish) begin
            err       <= 1'b1;
            quotient  <= 4'd0;
            remainder <= 4'd0;
          end else begin
            r_rem <= 4'd0;
            r_q   <= 3'd0;
            r_cnt <= 2'd2;
          end
        end
        S_DIV: begin
          // Quotient bits arrive MSB first, so shifting in fills q[i].
          r_rem <= w_ge ? w_diff : w_r;
          r_q   <= {r_q[1:0], w_ge};
          r_cnt <= r_cnt - 2'd1;
        end
        S_SIGN: begin
          err       <= 1'b0;
          quotient  <= w_q_signed;
          remainder <= w_rem_signed;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_division_4bits_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_division_4bits_ctrl
// Brief    : Directed self-checking bench for division_4bits_ctrl with a
//            behavioural model of the shared complement unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_division_4bits_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       comp_sel;
  logic [3:0] comp_a;
  logic [3:0] comp_b;
  logic       comp_ci;
  logic [3:0] comp_sum;
  logic       comp_finish;

  int checks   = 0;
  int failures = 0;

  // Complement unit model: registers |a| on a select, sticky finish flag.
  logic       m_fin;
  logic       fault_mode;

  int         sel_cnt  = 0;
  int         done_cnt = 0;
  logic [3:0] sel_log[$];

  division_4bits_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .quotient   (quotient),
    .remainder  (remainder),
    .comp_sel   (comp_sel),
    .comp_a     (comp_a),
    .comp_b     (comp_b),
    .comp_ci    (comp_ci),
    .comp_sum   (comp_sum),
    .comp_finish(comp_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      comp_sum <= 4'd0;
      m_fin    <= 1'b0;
    end else if (comp_sel) begin
      comp_sum <= comp_a[3] ? (4'd0 - comp_a) : comp_a;
      m_fin    <= 1'b1;
    end
  end

  assign comp_finish = fault_mode ? 1'b0 : m_fin;

  // Observe select pulses and done pulses.
  always @(negedge clk) begin
    if (comp_sel === 1'b1) begin
      sel_cnt = sel_cnt + 1;
      sel_log.push_back(comp_a);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
    end
  end

  // Issue one start, return cycles until done (30 means timeout) and results.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic [3:0] q,
                        output logic [3:0] r, output logic e);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (1) begin
      @(negedge clk);
      lat = lat + 1;
      if (done === 1'b1) break;
      if (lat >= 30) break;
    end
    q = quotient;
    r = remainder;
    e = err;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (quotient !== 4'b0000) begin failures++; $display("FAIL reset_quot got=%b exp=0000", quotient); end
    checks++; if (remainder !== 4'b0000) begin failures++; $display("FAIL reset_rem got=%b exp=0000", remainder); end
    checks++; if (comp_sel !== 1'b0 || comp_a !== 4'b0000) begin
      failures++; $display("FAIL reset_comp got sel=%b a=%b exp sel=0 a=0000", comp_sel, comp_a);
    end
    checks++; if (comp_b !== 4'b0000 || comp_ci !== 1'b1) begin
      failures++; $display("FAIL comp_const got b=%b ci=%b exp b=0000 ci=1", comp_b, comp_ci);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [3:0] q, r; logic e; int s0, n0;
    s0 = sel_log.size();
    n0 = sel_cnt;
    run_op(4'b0111, 4'b0010, lat, q, r, e);
    checks++; if (q !== 4'b0011) begin failures++; $display("FAIL div7_2_quot got=%b exp=0011", q); end
    checks++; if (r !== 4'b0001) begin failures++; $display("FAIL div7_2_rem got=%b exp=0001", r); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL div7_2_err got=%b exp=0", e); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL div7_2_latency got=%0d exp=9", lat); end
    checks++; if (sel_cnt - n0 !== 2) begin failures++; $display("FAIL div7_2_sel_pulses got=%0d exp=2", sel_cnt - n0); end
    if (sel_log.size() >= s0 + 2) begin
      checks++; if (sel_log[s0] !== 4'b0111 || sel_log[s0+1] !== 4'b0010) begin
        failures++; $display("FAIL div7_2_comp_a got=%b,%b exp=0111,0010", sel_log[s0], sel_log[s0+1]);
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL done_one_cycle got done=%b busy=%b exp 0 0", done, busy);
    end
    checks++; if (q !== quotient) begin failures++; $display("FAIL result_hold got=%b exp=%b", quotient, q); end
  endtask

  task automatic test_signed();
    int lat; logic [3:0] q, r; logic e;
    run_op(4'b1001, 4'b0010, lat, q, r, e);
    checks++; if (q !== 4'b1101 || r !== 4'b1111 || e !== 1'b0) begin
      failures++; $display("FAIL divm7_2 got q=%b r=%b err=%b exp q=1101 r=1111 err=0", q, r, e);
    end
    run_op(4'b0110, 4'b1101, lat, q, r, e);
    checks++; if (q !== 4'b1110 || r !== 4'b0000 || e !== 1'b0) begin
      failures++; $display("FAIL div6_m3 got q=%b r=%b err=%b exp q=1110 r=0000 err=0", q, r, e);
    end
    checks++; if (lat !== 9) begin failures++; $display("FAIL div6_m3_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_illegal();
    int lat; logic [3:0] q, r; logic e; int n0;
    logic [3:0] av[3];
    logic [3:0] bv[3];
    av[0] = 4'b1000; bv[0] = 4'b0001;
    av[1] = 4'b0101; bv[1] = 4'b0000;
    av[2] = 4'b0011; bv[2] = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      n0 = sel_cnt;
      run_op(av[k], bv[k], lat, q, r, e);
      checks++; if (e !== 1'b1 || q !== 4'b0000 || r !== 4'b0000) begin
        failures++; $display("FAIL illegal%0d got err=%b q=%b r=%b exp err=1 q=0000 r=0000", k, e, q, r);
      end
      checks++; if (lat !== 1) begin failures++; $display("FAIL illegal%0d_latency got=%0d exp=1", k, lat); end
      checks++; if (sel_cnt !== n0) begin failures++; $display("FAIL illegal%0d_sel got=%0d exp=0", k, sel_cnt - n0); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; int d0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'b0011;
    divisor  = 4'b0101;
    @(posedge clk);
    d0  = done_cnt;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat = lat + 1;
      if (done === 1'b1 || lat >= 30) break;
    end
    checks++; if (lat !== 9) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=9", lat); end
    checks++; if (quotient !== 4'b0000 || remainder !== 4'b0011 || err !== 1'b0) begin
      failures++; $display("FAIL div3_5 got q=%b r=%b err=%b exp q=0000 r=0011 err=0", quotient, remainder, err);
    end
    dividend = 4'b0111;
    divisor  = 4'b0010;
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (1) begin
      @(negedge clk);
      lat = lat + 1;
      if (done === 1'b1 || lat >= 30) break;
    end
    checks++; if (lat !== 9) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=9", lat); end
    checks++; if (quotient !== 4'b0011 || remainder !== 4'b0001) begin
      failures++; $display("FAIL b2b_second got q=%b r=%b exp q=0011 r=0001", quotient, remainder);
    end
    #1;
    checks++; if (done_cnt - d0 !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [3:0] q, r; logic e; int d0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'b0111;
    divisor  = 4'b0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0    = done_cnt;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL midrst_flags got busy=%b done=%b err=%b exp 0 0 0", busy, done, err);
    end
    checks++; if (quotient !== 4'b0000 || remainder !== 4'b0000) begin
      failures++; $display("FAIL midrst_results got q=%b r=%b exp 0000 0000", quotient, remainder);
    end
    checks++; if (comp_sel !== 1'b0 || comp_a !== 4'b0000) begin
      failures++; $display("FAIL midrst_comp got sel=%b a=%b exp 0 0000", comp_sel, comp_a);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    checks++; if (done_cnt !== d0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt - d0); end
    run_op(4'b0101, 4'b1111, lat, q, r, e);
    checks++; if (q !== 4'b1011 || r !== 4'b0000 || e !== 1'b0 || lat !== 9) begin
      failures++; $display("FAIL div5_m1 got q=%b r=%b err=%b lat=%0d exp q=1011 r=0000 err=0 lat=9", q, r, e, lat);
    end
  endtask

  task automatic test_fault();
    int lat; logic [3:0] q, r; logic e; int n0;
    fault_mode = 1'b1;
    n0 = sel_cnt;
    run_op(4'b0111, 4'b0010, lat, q, r, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL fault_err got=%b exp=1", e); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL fault_latency got=%0d exp=3", lat); end
    checks++; if (sel_cnt - n0 !== 1) begin failures++; $display("FAIL fault_sel_pulses got=%0d exp=1", sel_cnt - n0); end
    fault_mode = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    dividend   = 4'd0;
    divisor    = 4'd0;
    fault_mode = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_fault();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/division_4bits_ctrl.md
# division_4bits_ctrl

Sequencer for signed 4-bit two's-complement division. On each start it resolves operand magnitudes by driving the shared 4-bit complement unit twice, first with the dividend and then with the divisor. It then runs a 3-iteration restoring division on the magnitudes and applies the result signs. It sits between the calculator's operation decoder and the complement datapath, and it is the only block that drives that datapath's select and operand inputs.

## Interface
- No parameters; widths are fixed at 4 bits.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- dividend  in  4  signed two's complement; captured when start is accepted
- divisor  in  4  signed two's complement; captured when start is accepted
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; results are valid while done is high and held until the next accepted start
- err  out  1  set with done when an operand is illegal; held with the results
- quotient  out  4  signed quotient, truncated toward zero
- remainder  out  4  signed remainder; takes the dividend's sign
- comp_sel  out  1  to complement unit select input
- comp_a  out  4  to complement unit operand a
- comp_b  out  4  to complement unit operand b; constant 4'b0000
- comp_ci  out  1  to complement unit carry-in; constant 1
- comp_sum  in  4  from complement unit: magnitude, registered by the unit
- comp_finish  in  1  from complement unit: sticky completion flag

## Operation
- States: IDLE, REQ_A, CAP_A, REQ_B, CAP_B, DIV, SIGN, DONE.
- IDLE, start=1:
  - Latch the operands and the sign flags sa=dividend[3], sb=divisor[3].
  - If dividend==4'b1000, divisor==4'b1000 or divisor==0: go to DONE with err=1, quotient=0, remainder=0.
  - Otherwise go to REQ_A.
- REQ_A: comp_sel=1 and comp_a=latched dividend, both for exactly this cycle. The unit registers the magnitude at the end of the cycle.
- CAP_A:
  - comp_sel=0.
  - mag_a <= comp_sum[2:0].
  - If comp_finish==0, go to DONE with err=1; this is a datapath fault.
- REQ_B / CAP_B: the same sequence with the latched divisor; the result goes to mag_b.
- DIV: 3 cycles, iteration counter i=2,1,0. Each cycle:
  - r = {rem[2:0], mag_a[i]}.
  - If r >= {1'b0, mag_b}: rem <= r - mag_b and q[i] <= 1.
  - Otherwise: rem <= r and q[i] <= 0.
  - rem and q are cleared on entry to DIV.
- SIGN:
  - quotient <= (sa^sb) ? -{1'b0,q} : {1'b0,q}.
  - remainder <= sa ? -rem : rem.
  - Negation is the local 4-bit two's complement; the complement unit is not used here.
- DONE: done=1 for one cycle, then return to IDLE.
- comp_sel is 0 in every state except REQ_A and REQ_B.
- comp_a holds its last value when comp_sel is low.
- Arithmetic widths:
  - Magnitudes are 3 bits (0..7). -8 is excluded, because the unit maps it to magnitude 0.
  - rem is 4 bits and is never wider than the divisor magnitude.
  - Result magnitudes are at most 7, so signed results never overflow.

## Timing
- Reset (rst high at a rising edge) forces these values within that cycle's edge:
  - state = IDLE
  - busy = 0, done = 0, err = 0
  - quotient = 0, remainder = 0
  - comp_sel = 0, comp_a = 0
  - internal q, rem and counter cleared
- Reset mid-operation aborts without a done pulse.
- Start sampled at edge E0: busy=1 from E0.
  - Normal path: REQ_A during E0–E1, CAP_A E1–E2, REQ_B E2–E3, CAP_B E3–E4, DIV E4–E7, SIGN E7–E8, DONE E8–E9.
  - Normal-path done is high for the single cycle after E8, i.e. latency 9 cycles.
  - Illegal-operand path: done is high in the cycle after E0, latency 1 cycle.
- Back-to-back: start sampled in the IDLE cycle immediately after DONE is accepted. Throughput is 10 cycles per division.
- start while busy is ignored and not queued. Operand changes while busy have no effect.
- done and busy are never high together outside DONE; busy is high in DONE.
- Outputs only change at SIGN/DONE entry or reset.

## Test plan
- 7 / 2 (0111, 0010) -> quotient 0011, remainder 0001, err 0, done 9 cycles after start; comp_sel pulses exactly twice, with comp_a 0111 then 0010.
- -7 / 2 (1001, 0010) -> quotient 1101 (-3), remainder 1111 (-1); 6 / -3 (0110, 1101) -> quotient 1110, remainder 0000.
- Illegal operands: -8 dividend (1000 / 0001), divisor 0 (0101 / 0000) and -8 divisor -> err 1, quotient/remainder 0000, done 1 cycle after start, comp_sel never asserted.
- Start re-asserted each cycle during a 3 / 5 operation -> a single result (quotient 0000, remainder 0011), no second done; the next start accepted right after DONE completes in 9 cycles.
- rst asserted during DIV -> next cycle all outputs and comp_sel are 0, state IDLE, no done; a following 5 / -1 yields quotient 1011, remainder 0000.
- Complement unit model holding comp_finish at 0 -> err 1 and done in the cycle after CAP_A, with no REQ_B pulse.
